// File: rtl/adder_share_arbiter_pkg.sv
// rtl/adder_share_arbiter_pkg.sv - shared constants for the PC/branch adder arbiter
package adder_share_arbiter_pkg;

    localparam int PC_WIDTH = 10;

    localparam logic REQ_FETCH  = 1'b0;
    localparam logic REQ_BRANCH = 1'b1;

    localparam int PC_INCR = 4;

endpackage

// File: rtl/adder_share_arbiter_adder.sv
// rtl/adder_share_arbiter_adder.sv - modulo 2^W adder, carry-out dropped
module pc_adder #(
    parameter int W = 10
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/adder_share_arbiter_rr_arbiter2.sv
// rtl/adder_share_arbiter_rr_arbiter2.sv - two-way round-robin grant with last-grant pointer
module rr_arbiter2
    import adder_share_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] elig_i,
    output logic [1:0] grant_o,
    output logic       last_grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = 2'b00;
        last_d  = last_q;
        unique case (elig_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // on a tie the requester that did not win last time goes next
            2'b11:   grant_o = (last_q == REQ_BRANCH) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
        if (grant_o[0]) begin
            last_d = REQ_FETCH;
        end else if (grant_o[1]) begin
            last_d = REQ_BRANCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_BRANCH;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_grant_o = last_q;

endmodule

// File: rtl/adder_share_arbiter.sv
// rtl/adder_share_arbiter.sv - one shared adder time-shared between fetch and branch requesters
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int WIDTH = PC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    output logic             rsp0_valid,
    output logic [WIDTH-1:0] rsp0_sum,
    input  logic             rsp0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp1_valid,
    output logic [WIDTH-1:0] rsp1_sum,
    input  logic             rsp1_ready,
    output logic             last_grant
);

    logic [1:0]       elig;
    logic [1:0]       grant;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;

    logic             rsp0_valid_q, rsp0_valid_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp0_sum_q, rsp0_sum_d;
    logic [WIDTH-1:0] rsp1_sum_q, rsp1_sum_d;

    // a slot is free if empty or being drained this cycle
    assign elig[0] = req0_valid && (!rsp0_valid_q || rsp0_ready);
    assign elig[1] = req1_valid && (!rsp1_valid_q || rsp1_ready);

    rr_arbiter2 u_arb (
        .clk          (clk),
        .rst_n        (rst_n),
        .elig_i       (elig),
        .grant_o      (grant),
        .last_grant_o (last_grant)
    );

    assign add_a = grant[1] ? req1_a : req0_a;
    assign add_b = grant[1] ? req1_b : req0_b;

    pc_adder #(.W(WIDTH)) u_adder (
        .a_i   (add_a),
        .b_i   (add_b),
        .sum_o (add_sum)
    );

    always_comb begin
        rsp0_valid_d = rsp0_valid_q;
        rsp0_sum_d   = rsp0_sum_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_sum_d   = rsp1_sum_q;
        if (grant[0]) begin
            rsp0_valid_d = 1'b1;
            rsp0_sum_d   = add_sum;
        end else if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end
        if (grant[1]) begin
            rsp1_valid_d = 1'b1;
            rsp1_sum_d   = add_sum;
        end else if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_sum_q   <= '0;
            rsp1_sum_q   <= '0;
        end else begin
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_sum_q   <= rsp0_sum_d;
            rsp1_sum_q   <= rsp1_sum_d;
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_sum   = rsp0_sum_q;
    assign rsp1_sum   = rsp1_sum_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// tb/tb_adder_share_arbiter.sv - directed scoreboard bench for adder_share_arbiter
module tb_adder_share_arbiter;
    import adder_share_arbiter_pkg::*;

    localparam int W = 10;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0_valid, req1_valid;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp0_sum, rsp1_sum;
    logic         rsp0_ready, rsp1_ready;
    logic         last_grant;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];
    logic         mv0, mv1, mlast;

    always #5 clk = ~clk;

    adder_share_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .rsp0_valid (rsp0_valid),
        .rsp0_sum   (rsp0_sum),
        .rsp0_ready (rsp0_ready),
        .req1_valid (req1_valid),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .rsp1_valid (rsp1_valid),
        .rsp1_sum   (rsp1_sum),
        .rsp1_ready (rsp1_ready),
        .last_grant (last_grant)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] wsum(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] full;
        full = {1'b0, a} + {1'b0, b};
        return full[W-1:0];
    endfunction

    task automatic model_reset();
        mv0 = 1'b0;
        mv1 = 1'b0;
        mlast = 1'b1;
        q0.delete();
        q1.delete();
    endtask

    // one clock: check at negedge against the model, advance model, return #1 after posedge
    task automatic cyc();
        logic e0, e1, g0, g1;
        @(negedge clk);
        e0 = req0_valid && (!mv0 || rsp0_ready);
        e1 = req1_valid && (!mv1 || rsp1_ready);
        g0 = e0 && (!e1 || mlast == 1'b1);
        g1 = e1 && !g0;
        check("req0_ready", 32'(req0_ready), 32'(g0));
        check("req1_ready", 32'(req1_ready), 32'(g1));
        check("rsp0_valid", 32'(rsp0_valid), 32'(mv0));
        check("rsp1_valid", 32'(rsp1_valid), 32'(mv1));
        check("last_grant", 32'(last_grant), 32'(mlast));
        if (mv0) begin
            if (q0.size() == 0) check("q0_nonempty", 32'd0, 32'd1);
            else check("rsp0_sum", 32'(rsp0_sum), 32'(q0[0]));
        end
        if (mv1) begin
            if (q1.size() == 0) check("q1_nonempty", 32'd0, 32'd1);
            else check("rsp1_sum", 32'(rsp1_sum), 32'(q1[0]));
        end
        if (mv0 && rsp0_ready && q0.size() != 0) void'(q0.pop_front());
        if (mv1 && rsp1_ready && q1.size() != 0) void'(q1.pop_front());
        if (g0) q0.push_back(wsum(req0_a, req0_b));
        if (g1) q1.push_back(wsum(req1_a, req1_b));
        mv0 = g0 ? 1'b1 : (rsp0_ready ? 1'b0 : mv0);
        mv1 = g1 ? 1'b1 : (rsp1_ready ? 1'b0 : mv1);
        if (g0) mlast = 1'b0;
        else if (g1) mlast = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        model_reset();
        #12;
        check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
        check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
        check("rst_rsp0_sum", 32'(rsp0_sum), 32'd0);
        check("rst_rsp1_sum", 32'(rsp1_sum), 32'd0);
        check("rst_last_grant", 32'(last_grant), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) cyc();

        // fetch alone
        req0_valid = 1'b1; req0_a = 10'd100; req0_b = W'(PC_INCR);
        cyc();
        req0_valid = 1'b0;
        check("fetch_sum_104", 32'(rsp0_sum), 32'd104);
        cyc();

        // branch wrap 1022+4
        req1_valid = 1'b1; req1_a = 10'd1022; req1_b = 10'd4;
        cyc();
        req1_valid = 1'b0;
        check("wrap_sum_2", 32'(rsp1_sum), 32'd2);
        cyc();

        // contention, alternating grants starting with fetch
        req0_valid = 1'b1; req0_a = 10'd100; req0_b = 10'd4;
        req1_valid = 1'b1; req1_a = 10'd104; req1_b = 10'd1020;
        cyc();
        check("alt_first_fetch", 32'(rsp0_sum), 32'd104);
        cyc();
        check("alt_branch_wrap", 32'(rsp1_sum), 32'd100);
        repeat (4) cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) cyc();

        // fetch slot stuck full; branch takes every cycle
        req0_valid = 1'b1; req0_a = 10'd100; req0_b = 10'd4;
        cyc();
        rsp0_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 10'd300; req1_b = 10'd5;
        for (int i = 0; i < 5; i++) begin
            req0_a = 10'(500 + i);
            req1_b = 10'(5 + i);
            cyc();
            check("bp_hold_104", 32'(rsp0_sum), 32'd104);
            check("bp_branch_gnt", 32'(last_grant), 32'd1);
        end
        rsp0_ready = 1'b1; req0_a = 10'd100;
        #1;
        check("bp_regrant_now", 32'(req0_ready), 32'd1);
        cyc();
        req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (2) cyc();

        // consume and refill without a bubble
        req1_valid = 1'b1; req1_a = 10'd50; req1_b = 10'd8;
        cyc();
        req1_a = 10'd200; req1_b = 10'd8;
        cyc();
        check("refill_valid", 32'(rsp1_valid), 32'd1);
        check("refill_sum_208", 32'(rsp1_sum), 32'd208);
        req1_valid = 1'b0;
        repeat (2) cyc();

        // asynchronous reset with a result pending
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_a = 10'd7; req0_b = 10'd4;
        cyc();
        req0_valid = 1'b0;
        check("pre_reset_valid", 32'(rsp0_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid0", 32'(rsp0_valid), 32'd0);
        check("async_rst_sum0", 32'(rsp0_sum), 32'd0);
        check("async_rst_last", 32'(last_grant), 32'd1);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        repeat (2) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
